// File: rtl/exc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exc_sequencer_pkg
// Purpose  : Shared constants and FSM state encoding for the exception
//            sequencer slice (handler address, interrupt width, states).
// Revision : 1.0 - initial release
// ============================================================================
package exc_sequencer_pkg;

    localparam int          C_IRQ_W        = 6;
    localparam logic [31:0] C_HANDLER_ADDR = 32'h0000_4180;
    localparam logic [15:0] C_COUNT_MAX    = 16'hFFFF;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        GUARD = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/exc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : exc_sequencer_if
// Purpose  : Bundles the CP0 / pipeline control signals and the peripheral
//            interrupt bus seen by the exception sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface exc_sequencer_if;
    import exc_sequencer_pkg::*;

    logic               IntReq;
    logic               ERET_M;
    logic [31:0]        EPC;
    logic [C_IRQ_W-1:0] irq_in;
    logic [C_IRQ_W-1:0] irq_ack;
    logic [C_IRQ_W-1:0] HWInt;
    logic               EXLSet;
    logic               EXLClr;
    logic               flush;
    logic               redirect;
    logic [31:0]        pc_target;
    logic [15:0]        exc_count;

    // Environment side: drives requests, observes sequencer outputs.
    modport master (
        output IntReq, ERET_M, EPC, irq_in, irq_ack,
        input  HWInt, EXLSet, EXLClr, flush, redirect, pc_target, exc_count
    );

    // Sequencer side.
    modport slave (
        input  IntReq, ERET_M, EPC, irq_in, irq_ack,
        output HWInt, EXLSet, EXLClr, flush, redirect, pc_target, exc_count
    );

endinterface
`default_nettype wire

// File: rtl/exc_sequencer_irq_pending.sv
`default_nettype none
// ============================================================================
// Module   : irq_pending
// Purpose  : Per-line 2-flop synchronizer, rising-edge detector and sticky
//            pending register with acknowledge clear (edge beats ack).
// Revision : 1.0 - initial release
// ============================================================================
module irq_pending
    import exc_sequencer_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic [C_IRQ_W-1:0] irq_in,
    input  wire logic [C_IRQ_W-1:0] irq_ack,
    output logic      [C_IRQ_W-1:0] pending
);

    logic [C_IRQ_W-1:0] sync1_q, sync1_d;
    logic [C_IRQ_W-1:0] sync2_q, sync2_d;
    logic [C_IRQ_W-1:0] sync3_q, sync3_d;
    logic [C_IRQ_W-1:0] pending_q, pending_d;
    logic [C_IRQ_W-1:0] rise;

    // Synchronizer shift, edge detect, and pending set/clear.
    always_comb begin
        sync1_d   = irq_in;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;
        rise      = sync2_q & ~sync3_q;
        // A fresh edge must not be lost to an ack landing in the same cycle.
        pending_d = (pending_q & ~irq_ack) | rise;
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
            pending_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule
`default_nettype wire

// File: rtl/exc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : exc_sequencer
// Purpose  : Exception entry / eret sequencer: zero-latency PC redirect and
//            pipeline flush, one-cycle guard for the CP0 exl update, handler
//            entry counter, and registered peripheral interrupt pending.
// Revision : 1.0 - initial release
// ============================================================================
module exc_sequencer
    import exc_sequencer_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      reset,
    exc_sequencer_if.slave bus
);

    state_e      state_q, state_d;
    logic [15:0] exc_count_q, exc_count_d;
    logic        take_entry;

    irq_pending u_irq_pending (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (bus.irq_in),
        .irq_ack (bus.irq_ack),
        .pending (bus.HWInt)
    );

    // Next state and combinational control strobes; entry has priority over eret.
    always_comb begin
        state_d       = state_q;
        take_entry    = 1'b0;
        bus.EXLSet    = 1'b0;
        bus.EXLClr    = 1'b0;
        bus.flush     = 1'b0;
        bus.redirect  = 1'b0;
        bus.pc_target = '0;
        // Outputs are held quiet for the whole reset interval, not just after an edge.
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (bus.IntReq) begin
                        take_entry    = 1'b1;
                        bus.EXLSet    = 1'b1;
                        bus.flush     = 1'b1;
                        bus.redirect  = 1'b1;
                        bus.pc_target = C_HANDLER_ADDR;
                        state_d       = GUARD;
                    end else if (bus.ERET_M) begin
                        bus.EXLClr    = 1'b1;
                        bus.flush     = 1'b1;
                        bus.redirect  = 1'b1;
                        bus.pc_target = bus.EPC;
                        state_d       = GUARD;
                    end
                end
                // Requests are ignored while CP0 exl settles.
                GUARD:   state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // Saturating count of handler entries.
    always_comb begin
        exc_count_d = exc_count_q;
        if (take_entry && (exc_count_q != C_COUNT_MAX)) begin
            exc_count_d = exc_count_q + 16'd1;
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            exc_count_q <= '0;
        end else begin
            state_q     <= state_d;
            exc_count_q <= exc_count_d;
        end
    end

    assign bus.exc_count = exc_count_q;

endmodule
`default_nettype wire

// File: tb/tb_exc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_exc_sequencer
// Purpose  : Self-checking bench for exc_sequencer: directed scenarios plus
//            randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exc_sequencer;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    exc_sequencer_if bus ();

    exc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Holds reset across two edges; returns at a falling edge with reset low.
    task automatic apply_reset();
        reset       = 1'b1;
        bus.IntReq  = 1'b0;
        bus.ERET_M  = 1'b0;
        bus.EPC     = '0;
        bus.irq_in  = '0;
        bus.irq_ack = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        bus.irq_in = 6'b000001;
        bus.IntReq = 1'b1;
        bus.ERET_M = 1'b1;
        bus.EPC    = 32'hDEAD_BEEF;
        reset      = 1'b1;
        #1;
        vectors++;
        if ({bus.EXLSet, bus.EXLClr, bus.flush, bus.redirect, bus.pc_target} !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %h expected 0", {bus.EXLSet, bus.EXLClr, bus.flush, bus.redirect, bus.pc_target});
        end
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if ({bus.HWInt, bus.exc_count} !== 22'h0) begin
            miscompares++;
            $display("FAIL reset_state: got HWInt=%b count=%h expected 0/0", bus.HWInt, bus.exc_count);
        end
    endtask

    task automatic test_entry();
        apply_reset();
        bus.IntReq = 1'b1;
        #1;
        vectors++;
        if ({bus.EXLSet, bus.EXLClr, bus.flush, bus.redirect, bus.pc_target} !== {4'b1011, 32'h0000_4180}) begin
            miscompares++;
            $display("FAIL entry_ctl: got %h expected %h", {bus.EXLSet, bus.EXLClr, bus.flush, bus.redirect, bus.pc_target}, {4'b1011, 32'h0000_4180});
        end
        @(negedge clk);
        bus.IntReq = 1'b0;
        #1;
        vectors++;
        if ({bus.EXLSet, bus.EXLClr, bus.flush, bus.redirect, bus.pc_target} !== 36'h0 || bus.exc_count !== 16'd1) begin
            miscompares++;
            $display("FAIL entry_guard: got ctl=%h count=%h expected 0/0001", {bus.EXLSet, bus.EXLClr, bus.flush, bus.redirect, bus.pc_target}, bus.exc_count);
        end
    endtask

    task automatic test_eret();
        apply_reset();
        bus.ERET_M = 1'b1;
        bus.EPC    = 32'h0000_3010;
        #1;
        vectors++;
        if ({bus.EXLSet, bus.EXLClr, bus.flush, bus.redirect, bus.pc_target} !== {4'b0111, 32'h0000_3010}) begin
            miscompares++;
            $display("FAIL eret_ctl: got %h expected %h", {bus.EXLSet, bus.EXLClr, bus.flush, bus.redirect, bus.pc_target}, {4'b0111, 32'h0000_3010});
        end
        @(negedge clk);
        bus.ERET_M = 1'b0;
        bus.IntReq = 1'b1;
        #1;
        vectors++;
        if ({bus.EXLSet, bus.EXLClr, bus.flush, bus.redirect, bus.pc_target} !== 36'h0) begin
            miscompares++;
            $display("FAIL eret_guard_ignores_intreq: got %h expected 0", {bus.EXLSet, bus.EXLClr, bus.flush, bus.redirect, bus.pc_target});
        end
        @(negedge clk);
        bus.IntReq = 1'b0;
        #1;
        vectors++;
        if (bus.exc_count !== 16'd0) begin
            miscompares++;
            $display("FAIL eret_count: got %h expected 0000", bus.exc_count);
        end
    endtask

    task automatic test_priority();
        apply_reset();
        bus.IntReq = 1'b1;
        bus.ERET_M = 1'b1;
        bus.EPC    = 32'h0000_3010;
        #1;
        vectors++;
        if ({bus.EXLSet, bus.EXLClr, bus.flush, bus.redirect, bus.pc_target} !== {4'b1011, 32'h0000_4180}) begin
            miscompares++;
            $display("FAIL priority_ctl: got %h expected %h", {bus.EXLSet, bus.EXLClr, bus.flush, bus.redirect, bus.pc_target}, {4'b1011, 32'h0000_4180});
        end
        @(negedge clk);
        bus.IntReq = 1'b0;
        bus.ERET_M = 1'b0;
    endtask

    task automatic test_irq_level();
        apply_reset();
        bus.irq_in = 6'b000100;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (bus.HWInt !== ((e >= 3) ? 6'b000100 : 6'b000000)) begin
                miscompares++;
                $display("FAIL irq_level edge %0d: got %b expected %b", e, bus.HWInt, (e >= 3) ? 6'b000100 : 6'b000000);
            end
        end
        @(negedge clk);
        bus.irq_ack = 6'b000100;
        @(negedge clk);
        bus.irq_ack = 6'b000000;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (bus.HWInt !== 6'b000000) begin
                miscompares++;
                $display("FAIL irq_ack_held_level cycle %0d: got %b expected 000000", c, bus.HWInt);
            end
        end
        @(negedge clk);
        bus.irq_in = 6'b000000;
        repeat (3) @(negedge clk);
        bus.irq_in = 6'b000100;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.HWInt !== 6'b000100) begin
            miscompares++;
            $display("FAIL irq_rearm: got %b expected 000100", bus.HWInt);
        end
    endtask

    task automatic test_ack_collision();
        apply_reset();
        bus.irq_in = 6'b000001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.irq_ack = 6'b000001;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.HWInt[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL ack_collision: got %b expected 1", bus.HWInt[0]);
        end
        @(negedge clk);
        bus.irq_ack = 6'b000000;
    endtask

    task automatic test_saturation();
        apply_reset();
        bus.irq_in = 6'b100000;
        force dut.exc_count_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.exc_count_q;
        #1;
        vectors++;
        if (bus.exc_count !== 16'hFFFE) begin
            miscompares++;
            $display("FAIL sat_preload: got %h expected fffe", bus.exc_count);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.IntReq = 1'b1;
            @(negedge clk);
            bus.IntReq = 1'b0;
            #1;
            vectors++;
            if (bus.exc_count !== 16'hFFFF) begin
                miscompares++;
                $display("FAIL sat_entry %0d: got %h expected ffff", k, bus.exc_count);
            end
        end
        vectors++;
        if (bus.HWInt !== 6'b100000) begin
            miscompares++;
            $display("FAIL sat_pending_before_reset: got %b expected 100000", bus.HWInt);
        end
        // Now mid-GUARD: async reset must clear everything before any edge.
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus.HWInt, bus.exc_count, bus.EXLSet, bus.EXLClr, bus.flush, bus.redirect, bus.pc_target} !== 58'h0) begin
            miscompares++;
            $display("FAIL async_reset_guard: got HWInt=%b count=%h pc=%h expected all 0", bus.HWInt, bus.exc_count, bus.pc_target);
        end
        bus.irq_in = 6'b000000;
        @(negedge clk);
        reset      = 1'b0;
        bus.IntReq = 1'b1;
        #1;
        vectors++;
        if ({bus.EXLSet, bus.EXLClr, bus.flush, bus.redirect, bus.pc_target} !== {4'b1011, 32'h0000_4180}) begin
            miscompares++;
            $display("FAIL post_reset_entry: got %h expected %h", {bus.EXLSet, bus.EXLClr, bus.flush, bus.redirect, bus.pc_target}, {4'b1011, 32'h0000_4180});
        end
        @(negedge clk);
        bus.IntReq = 1'b0;
    endtask

    // Random traffic against a model built from the behavioural rules:
    // a serviced request blocks the following cycle, each entry counts
    // (saturating), and an input rise sampled at edge n becomes pending at
    // edge n+2 unless it was still high at the previous sample.
    task automatic test_random();
        logic        blocked;
        logic [15:0] m_count;
        logic [5:0]  m_pend;
        logic [5:0]  samples[$];
        logic        is_entry, is_eret;
        logic [35:0] exp_ctl;
        apply_reset();
        blocked = 1'b0;
        m_count = '0;
        m_pend  = '0;
        samples = '{6'h0, 6'h0, 6'h0};
        for (int n = 0; n < 400; n++) begin
            bus.IntReq  = ($urandom_range(0, 9) < 3);
            bus.ERET_M  = ($urandom_range(0, 9) < 3);
            bus.EPC     = $urandom;
            if ($urandom_range(0, 5) == 0) bus.irq_in = bus.irq_in ^ 6'(1 << $urandom_range(0, 5));
            bus.irq_ack = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
            #1;
            is_entry = !blocked && bus.IntReq;
            is_eret  = !blocked && !bus.IntReq && bus.ERET_M;
            exp_ctl  = is_entry ? {4'b1011, 32'h0000_4180} :
                       is_eret  ? {4'b0111, bus.EPC} : 36'h0;
            vectors++;
            if ({bus.EXLSet, bus.EXLClr, bus.flush, bus.redirect, bus.pc_target} !== exp_ctl
                || bus.HWInt !== m_pend || bus.exc_count !== m_count) begin
                miscompares++;
                $display("FAIL random cycle %0d: got ctl=%h hw=%b cnt=%h expected ctl=%h hw=%b cnt=%h",
                         n, {bus.EXLSet, bus.EXLClr, bus.flush, bus.redirect, bus.pc_target}, bus.HWInt,
                         bus.exc_count, exp_ctl, m_pend, m_count);
            end
            blocked = is_entry || is_eret;
            if (is_entry && m_count != 16'hFFFF) m_count = m_count + 16'd1;
            m_pend = (m_pend & ~bus.irq_ack) | (samples[1] & ~samples[0]);
            samples.push_back(bus.irq_in);
            void'(samples.pop_front());
            @(negedge clk);
        end
        bus.IntReq = 1'b0;
        bus.ERET_M = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_entry();
        test_eret();
        test_priority();
        test_irq_level();
        test_ack_collision();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exc_sequencer.md
EXC_SEQUENCER -- requirements
Module: exc_sequencer

Interface
REQ-001 SHALL have no parameters; handler entry address 32'h0000_4180 is a shared package constant.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 IntReq  input  1  CP0 combined interrupt/exception request, valid for the M-stage instruction this cycle.
REQ-005 ERET_M  input  1  M-stage instruction is eret.
REQ-006 EPC  input  32  CP0 EPC value.
REQ-007 irq_in  input  6  raw level peripheral interrupt lines, asynchronous to clk.
REQ-008 irq_ack  input  6  one-hot-or-more pending-clear strobes from the bus.
REQ-009 HWInt  output  6  registered pending vector, drives CP0 HWInt[15:10].
REQ-010 EXLSet  output  1  CP0 exl set strobe.
REQ-011 EXLClr  output  1  CP0 exl clear strobe.
REQ-012 flush  output  1  kill F/D/E/M pipeline registers this edge.
REQ-013 redirect  output  1  PC override valid.
REQ-014 pc_target  output  32  PC override value, 0 when redirect=0.
REQ-015 exc_count  output  16  number of handler entries taken, saturating.

Function
REQ-016 SHALL implement FSM states RUN and GUARD.
REQ-017 In RUN with IntReq=1: EXLSet=1, flush=1, redirect=1, pc_target=32'h0000_4180 in the same cycle (combinational, zero latency); next state GUARD.
REQ-018 In RUN with IntReq=0 and ERET_M=1: EXLClr=1, flush=1, redirect=1, pc_target=EPC in the same cycle; next state GUARD.
REQ-019 IntReq=1 and ERET_M=1 simultaneously: entry (REQ-017) wins; EXLClr SHALL stay 0.
REQ-020 In GUARD: all strobes, flush, redirect 0; IntReq and ERET_M ignored; next state RUN unconditionally (covers the one-cycle exl update latency in CP0).
REQ-021 In RUN with neither request: all strobes 0, state unchanged.
REQ-022 EXLSet and EXLClr SHALL never be 1 in the same cycle.
REQ-023 Each irq_in bit SHALL pass a 2-flop synchronizer, then a rising-edge detector (sync_q2 & ~sync_q3).
REQ-024 Pending bit i set on detected edge i; cleared on irq_ack[i]; edge and ack same cycle -> bit stays/becomes 1.
REQ-025 HWInt = pending register; first visibility 3 rising edges after an irq_in rise that meets setup.
REQ-026 A level held high SHALL set pending only once; re-set requires a fall then rise.
REQ-027 exc_count increments by 1 on every REQ-017 entry cycle; holds at 16'hFFFF.

Reset
REQ-028 While reset=1, independent of clk: state=RUN, synchronizer and edge flops 0, pending 0, exc_count 0; hence HWInt=0, EXLSet=EXLClr=flush=redirect=0, pc_target=0.
REQ-029 Reset asserted in GUARD SHALL return to RUN; first post-reset cycle with IntReq=1 is serviced normally.

Structure
REQ-030 Shared package holds the handler address, FSM state encoding (RUN=1'b0, GUARD=1'b1) and the 6-bit interrupt width.
REQ-031 One sub-module irq_pending (synchronizer, edge detect, pending set/clear for 6 lines) SHALL be instantiated; FSM and counter stay in exc_sequencer.

Verification
REQ-032 RUN, IntReq=1 one cycle -> same cycle EXLSet=1, flush=1, pc_target=32'h0000_4180; next cycle GUARD, all 0; exc_count=1.
REQ-033 RUN, ERET_M=1, EPC=32'h0000_3010 -> same cycle EXLClr=1, redirect=1, pc_target=32'h0000_3010; IntReq=1 on following cycle ignored (GUARD).
REQ-034 IntReq=1 and ERET_M=1 together -> pc_target=32'h0000_4180, EXLClr=0, EXLSet=1.
REQ-035 irq_in[2] 0->1 held 10 cycles -> HWInt=6'b000100 from edge 3 on; irq_ack[2] pulse -> HWInt=0 and stays 0 while irq_in[2] remains high.
REQ-036 irq_ack[0] coincident with detected edge on line 0 -> HWInt[0]=1 afterwards.
REQ-037 Preload exc_count to 16'hFFFE via 2 cycles... then 2 further entries -> 16'hFFFF; reset asserted mid-GUARD asynchronously -> all outputs 0 before next clk edge.
